controlador_animacao: RTL and testbench
=======================================

CONTROLADOR_ANIMACAO -- requirements
Module: controlador_animacao

Interface
REQ-001 SHALL have parameter N_STATS, default 3; number of status bars.
REQ-002 SHALL have parameter FRAME_DIV, default 8388608; clock cycles per animation tick, minimum 2.
REQ-003 SHALL have parameter BAR_ROW0, default 8; 8-byte row index of bar 0.
REQ-004 SHALL have parameter BAR_PITCH, default 10; row spacing between consecutive bars.
REQ-005 SHALL have parameter BAR_ROWS, default 5; rows per bar.
REQ-006 SHALL have port clk, input, 1 bit; the only clock.
REQ-007 SHALL have port rst_n, input, 1 bit; reset, synchronous and active-low.
REQ-008 SHALL have port byte_counter, input, 10 bits; framebuffer byte index 0..1023.
REQ-009 SHALL have port byte_req, input, 1 bit; byte request strobe.
REQ-010 SHALL have port estado, input, 5 bits; one-hot state: INTRO=0, IDLE=1, DORMINDO=2, COMENDO=4, DANDO_AULA=8, MORTO=16.
REQ-011 SHALL have port stats, input, N_STATS*8 bits; stat k is in bits [8k+7:8k], values 0..255.
REQ-012 SHALL have port pause, input, 1 bit; freezes animation.
REQ-013 SHALL have port data_to_send, output, 8 bits; pixel byte.
REQ-014 SHALL have port data_valid, output, 1 bit; data_to_send is valid.
REQ-015 SHALL have port frame_idx, output, 3 bits; current animation frame.

Function
REQ-016 Frame counts SHALL be: INTRO 1, IDLE 6, DORMINDO 4, COMENDO 5, DANDO_AULA 7, MORTO 8; any other estado value SHALL be treated as IDLE.
REQ-017 A divider SHALL count 0..FRAME_DIV-1 and raise one-cycle tick at terminal count; the divider SHALL keep running during pause.
REQ-018 A tick SHALL set pend_adv; pend_adv SHALL be applied only on an accepted request with byte_counter==0 (tear-free frame boundary), then cleared; repeated ticks before application SHALL collapse into one advance.
REQ-019 Advance: frame_idx <= (frame_idx+1) mod frames(estado); wrap from last frame to 0; MORTO SHALL hold at frame 7 and not wrap.
REQ-020 When pause=1, advances SHALL be suppressed and pend_adv SHALL be held, not lost.
REQ-021 A change of estado, compared with a registered copy, SHALL clear frame_idx to 0 and pend_adv on the following cycle; state change SHALL take priority over a simultaneous advance.
REQ-022 Latency: byte_req at cycle N SHALL produce data_valid=1 and data_to_send at N+1; data_valid=0 and data_to_send held when there is no request; back-to-back requests SHALL be accepted every cycle.
REQ-023 Pixel source: ROM word at (base(estado) + frame_idx*1024 + byte_counter); bases are packed in the order INTRO, IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO, giving 31 frames and 31744 bytes total.
REQ-024 Bar k region: row r = byte_counter[9:3] in [BAR_ROW0+k*BAR_PITCH, +BAR_ROWS-1]; segment s = byte_counter[2:0] in 1..5.
REQ-025 Stat values above 100 SHALL be saturated to 100 before comparison.
REQ-026 In a bar region, segment s SHALL output 0xEE if v > 110-20s, else 0xE0 if v > 100-20s, else 0x00 (v=0 gives all 0x00; v=100 gives all 0xEE).
REQ-027 Where bar regions overlap, the lowest k SHALL win; bars SHALL never be drawn in INTRO.

Reset
REQ-028 While rst_n=0 at a clk edge, the following SHALL be cleared: data_to_send=0x00, data_valid=0, frame_idx=0, divider=0, pend_adv=0, and the registered estado SHALL be set to INTRO.
REQ-029 Reset mid-frame SHALL abort any pending advance; the first request after reset SHALL return INTRO frame 0 data.

Configuration
REQ-030 Macro STATUS_BARS_EN defined: bar overlay present per REQ-024..027.
REQ-031 Macro STATUS_BARS_EN undefined: stats is ignored, all bytes come from ROM, and no comparator logic SHALL be synthesised.

Structure
REQ-032 Package tamagotchi_pkg SHALL hold the estado encodings, frame counts, ROM bases, FULL_SEG=0xEE, HALF_SEG=0xE0, and FRAME_BYTES=1024.
REQ-033 A sub-module sprite_rom SHALL be used: synchronous 1-cycle read, initialised from hexs/<State>/*.hex files.

Verification
REQ-034 Reset, then byte_req with byte_counter=5 and estado=INTRO -> next cycle data_valid=1, data = intro[5], frame_idx=0.
REQ-035 estado=IDLE, FRAME_DIV=4, six ticks each followed by a request at byte 0 -> frame_idx sequence 1,2,3,4,5,0.
REQ-036 Stats = {84,22,34}, byte_counter=67 (bar 0, segment 3) -> 0x00; byte 147 (bar 1, segment 3) -> 0x00; byte 227 (bar 2, segment 3) -> 0xEE; byte 225 (bar 2, segment 1) -> 0xE0.
REQ-037 Stat 0 = 200 -> bar 0 segments 1..5 all 0xEE.
REQ-038 Tick arrives with pause=1, then pause is released and a request at byte 0 -> exactly one advance.
REQ-039 DANDO_AULA at frame 4, estado changes to COMENDO in the same cycle as an advance -> frame_idx=0; MORTO at frame 7 with a tick -> frame_idx stays 7.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Shared encodings, sprite ROM layout and status-bar segment helper for the tamagotchi display path.
package tamagotchi_pkg;

    localparam logic [4:0] EST_INTRO      = 5'd0;
    localparam logic [4:0] EST_IDLE       = 5'd1;
    localparam logic [4:0] EST_DORMINDO   = 5'd2;
    localparam logic [4:0] EST_COMENDO    = 5'd4;
    localparam logic [4:0] EST_DANDO_AULA = 5'd8;
    localparam logic [4:0] EST_MORTO      = 5'd16;

    localparam int unsigned FRAME_BYTES = 1024;
    localparam int unsigned ROM_FRAMES  = 31;
    localparam int unsigned ROM_BYTES   = ROM_FRAMES * FRAME_BYTES;
    localparam int unsigned ROM_AW      = $clog2(ROM_BYTES);

    localparam logic [7:0] FULL_SEG = 8'hEE;
    localparam logic [7:0] HALF_SEG = 8'hE0;

    typedef enum logic [2:0] {
        S_INTRO,
        S_IDLE,
        S_DORMINDO,
        S_COMENDO,
        S_DANDO_AULA,
        S_MORTO
    } sprite_e;

    // Unknown estado codes fall back to the IDLE animation.
    function automatic sprite_e decode_estado(input logic [4:0] estado);
        case (estado)
            EST_INTRO:      return S_INTRO;
            EST_IDLE:       return S_IDLE;
            EST_DORMINDO:   return S_DORMINDO;
            EST_COMENDO:    return S_COMENDO;
            EST_DANDO_AULA: return S_DANDO_AULA;
            EST_MORTO:      return S_MORTO;
            default:        return S_IDLE;
        endcase
    endfunction

    function automatic logic [3:0] frame_count(input sprite_e s);
        case (s)
            S_INTRO:      return 4'd1;
            S_DORMINDO:   return 4'd4;
            S_COMENDO:    return 4'd5;
            S_DANDO_AULA: return 4'd7;
            S_MORTO:      return 4'd8;
            default:      return 4'd6;
        endcase
    endfunction

    // First frame of each animation inside the packed ROM.
    function automatic logic [4:0] frame_base(input sprite_e s);
        case (s)
            S_INTRO:      return 5'd0;
            S_DORMINDO:   return 5'd7;
            S_COMENDO:    return 5'd11;
            S_DANDO_AULA: return 5'd16;
            S_MORTO:      return 5'd23;
            default:      return 5'd1;
        endcase
    endfunction

    function automatic logic [7:0] seg_byte(input logic [7:0] raw, input logic [2:0] seg);
        logic [7:0] v;
        logic [7:0] half_thr;
        logic [7:0] full_thr;
        v        = (raw > 8'd100) ? 8'd100 : raw;
        half_thr = 8'd100 - 8'(seg) * 8'd20;
        full_thr = half_thr + 8'd10;
        if (v > full_thr) return FULL_SEG;
        if (v > half_thr) return HALF_SEG;
        return 8'h00;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite ROM with a registered one-cycle read; output holds when en_i is low.
// Contents are an address-derived image standing in for the hexs/<State>/*.hex artwork.
module sprite_rom
    import tamagotchi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [7:0]        data_o
);

    logic [7:0] data_q;

    function automatic logic [7:0] image_byte(input logic [ROM_AW-1:0] a);
        return 8'(a[7:0] ^ {6'd0, a[9:8]}) + 8'(a[14:10]) * 8'd29;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= 8'h00;
        end else if (en_i) begin
            data_q <= image_byte(addr_i);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/controlador_animacao.sv
// Animation controller: frame sequencing on tear-free boundaries plus sprite/status-bar pixel fetch.
// Define STATUS_BARS_EN to overlay the stat bars on the sprite image.
module controlador_animacao
    import tamagotchi_pkg::*;
#(
    parameter int unsigned N_STATS   = 3,
    parameter int unsigned FRAME_DIV = 8388608,
    parameter int unsigned BAR_ROW0  = 8,
    parameter int unsigned BAR_PITCH = 10,
    parameter int unsigned BAR_ROWS  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           byte_counter,
    input  logic                 byte_req,
    input  logic [4:0]           estado,
    input  logic [N_STATS*8-1:0] stats,
    input  logic                 pause,
    output logic [7:0]           data_to_send,
    output logic                 data_valid,
    output logic [2:0]           frame_idx
);

    localparam int unsigned DIV_W = $clog2(FRAME_DIV);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              pend_q, pend_d;
    logic [2:0]        frame_q, frame_d;
    logic [4:0]        estado_q;
    logic              valid_q;

    sprite_e           spr_c;
    logic [3:0]        n_frames_c;
    logic              tick_c;
    logic              changed_c;
    logic              apply_c;
    logic [2:0]        next_frame_c;
    logic [ROM_AW-1:0] rom_addr_c;
    logic [7:0]        rom_data;

    // Divider, pending-advance flag and frame sequencing.
    always_comb begin
        spr_c      = decode_estado(estado);
        n_frames_c = frame_count(spr_c);
        tick_c     = (div_q == DIV_W'(FRAME_DIV - 1));
        div_d      = tick_c ? '0 : div_q + DIV_W'(1);
        changed_c  = (estado != estado_q);
        apply_c    = byte_req && (byte_counter == 10'd0) && !pause && pend_q;

        if (spr_c == S_MORTO && frame_q == 3'd7) begin
            next_frame_c = frame_q;
        end else if ({1'b0, frame_q} + 4'd1 >= n_frames_c) begin
            next_frame_c = 3'd0;
        end else begin
            next_frame_c = frame_q + 3'd1;
        end

        frame_d = frame_q;
        pend_d  = pend_q | tick_c;
        if (changed_c) begin
            frame_d = 3'd0;
            pend_d  = 1'b0;
        end else if (apply_c) begin
            frame_d = next_frame_c;
            pend_d  = tick_c;
        end

        rom_addr_c = {frame_base(spr_c) + 5'(frame_q), byte_counter};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            pend_q   <= 1'b0;
            frame_q  <= 3'd0;
            estado_q <= EST_INTRO;
            valid_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
            estado_q <= estado;
            valid_q  <= byte_req;
        end
    end

    sprite_rom u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (byte_req),
        .addr_i (rom_addr_c),
        .data_o (rom_data)
    );

`ifdef STATUS_BARS_EN
    logic        bar_hit_c, bar_hit_q;
    logic [7:0]  bar_byte_c, bar_byte_q;
    int unsigned row_c;

    // Lowest-numbered bar claims the byte where regions overlap.
    always_comb begin
        bar_hit_c  = 1'b0;
        bar_byte_c = 8'h00;
        row_c      = 32'(byte_counter[9:3]);
        for (int unsigned k = 0; k < N_STATS; k++) begin
            if (!bar_hit_c && spr_c != S_INTRO
                && byte_counter[2:0] >= 3'd1 && byte_counter[2:0] <= 3'd5
                && row_c >= BAR_ROW0 + k * BAR_PITCH
                && row_c <  BAR_ROW0 + k * BAR_PITCH + BAR_ROWS) begin
                bar_hit_c  = 1'b1;
                bar_byte_c = seg_byte(stats[8*k +: 8], byte_counter[2:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_hit_q  <= 1'b0;
            bar_byte_q <= 8'h00;
        end else if (byte_req) begin
            bar_hit_q  <= bar_hit_c;
            bar_byte_q <= bar_byte_c;
        end
    end

    assign data_to_send = bar_hit_q ? bar_byte_q : rom_data;
`else
    localparam int unsigned UNUSED_BAR_CFG = BAR_ROW0 + BAR_PITCH + BAR_ROWS;
    logic unused_stats;
    assign unused_stats = ^stats;
    assign data_to_send = rom_data;
`endif

    assign data_valid = valid_q;
    assign frame_idx  = frame_q;

endmodule

// File: tb/tb_controlador_animacao.sv
// Directed bench for controlador_animacao: scoreboard of expected pixel bytes plus frame sequencing checks.
module tb_controlador_animacao;

    localparam int unsigned FDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  byte_counter;
    logic        byte_req;
    logic [4:0]  estado;
    logic [23:0] stats;
    logic        pause;
    logic [7:0]  data_to_send;
    logic        data_valid;
    logic [2:0]  frame_idx;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic        req_seen = 1'b0;
    logic        chk_en   = 1'b0;
    logic [7:0]  last_data = 8'h00;

    logic [4:0]  m_est   = 5'd0;
    int unsigned m_frame = 0;
    logic        m_pend  = 1'b0;

    controlador_animacao #(
        .N_STATS   (3),
        .FRAME_DIV (FDIV),
        .BAR_ROW0  (8),
        .BAR_PITCH (10),
        .BAR_ROWS  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_counter (byte_counter),
        .byte_req     (byte_req),
        .estado       (estado),
        .stats        (stats),
        .pause        (pause),
        .data_to_send (data_to_send),
        .data_valid   (data_valid),
        .frame_idx    (frame_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] rom_model(input int unsigned addr);
        return 8'(((addr & 32'd255) ^ ((addr >> 8) & 32'd3)) + (addr >> 10) * 32'd29);
    endfunction

    function automatic int unsigned base_frames(input logic [4:0] e);
        case (e)
            5'd0:    return 0;
            5'd2:    return 7;
            5'd4:    return 11;
            5'd8:    return 16;
            5'd16:   return 23;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned n_frames(input logic [4:0] e);
        case (e)
            5'd0:    return 1;
            5'd2:    return 4;
            5'd4:    return 5;
            5'd8:    return 7;
            5'd16:   return 8;
            default: return 6;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [4:0] e, input int unsigned fr,
                                            input int unsigned bc, input logic [23:0] st);
        logic [7:0] b;
        b = rom_model((base_frames(e) + fr) * 1024 + bc);
`ifdef STATUS_BARS_EN
        begin
            int unsigned row;
            int unsigned seg;
            int unsigned v;
            logic        hit;
            row = bc / 8;
            seg = bc % 8;
            hit = 1'b0;
            if (e != 5'd0 && seg >= 1 && seg <= 5) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    if (!hit && row >= 8 + k * 10 && row <= 12 + k * 10) begin
                        hit = 1'b1;
                        v = 32'(st[8*k +: 8]);
                        if (v > 100) v = 100;
                        if (v > 110 - 20 * seg)      b = 8'hEE;
                        else if (v > 100 - 20 * seg) b = 8'hE0;
                        else                         b = 8'h00;
                    end
                end
            end
        end
`endif
        return b;
    endfunction

    // Scoreboard side: every cycle data_valid must follow the request, data is popped or held.
    always @(posedge clk) req_seen <= rst_n && byte_req;

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(data_valid), 32'(req_seen));
            if (req_seen) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $error("FAIL sb_empty: got data %0h with no expected entry", data_to_send);
                end else begin
                    last_data = exp_q.pop_front();
                    check("data", 32'(data_to_send), 32'(last_data));
                end
            end else begin
                check("hold", 32'(data_to_send), 32'(last_data));
            end
        end
    end

    task automatic idle(input int n);
        byte_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Enough idle cycles that at least one tick has certainly set the pending flag.
    task automatic wait_tick();
        idle(FDIV + 1);
        m_pend = 1'b1;
    endtask

    task automatic advance_model();
        if (!(m_est == 5'd16 && m_frame == 7)) m_frame = (m_frame + 1) % n_frames(m_est);
    endtask

    task automatic req(input int unsigned bc);
        byte_req     = 1'b1;
        byte_counter = 10'(bc);
        exp_q.push_back(exp_byte(m_est, m_frame, bc, stats));
        if (bc == 0 && !pause && m_pend) begin
            advance_model();
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        check("frame", 32'(frame_idx), m_frame);
    endtask

    task automatic req_change(input logic [4:0] e, input int unsigned bc);
        byte_req     = 1'b1;
        byte_counter = 10'(bc);
        estado       = e;
        exp_q.push_back(exp_byte(e, m_frame, bc, stats));
        m_est   = e;
        m_frame = 0;
        m_pend  = 1'b0;
        @(posedge clk);
        #1;
        check("chg_frame", 32'(frame_idx), m_frame);
    endtask

    task automatic set_estado(input logic [4:0] e);
        estado = e;
        idle(1);
        m_est   = e;
        m_frame = 0;
        m_pend  = 1'b0;
        check("est_clear", 32'(frame_idx), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        byte_req     = 1'b1;
        byte_counter = 10'd5;
        estado       = 5'd4;
        stats        = '0;
        pause        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_to_send), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_frame", 32'(frame_idx), 0);
        byte_req = 1'b0;
        estado   = 5'd0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // INTRO frame 0, no bars.
        req(5);
        req(67);
        idle(2);

        // IDLE sequencing 1,2,3,4,5,0.
        set_estado(5'd1);
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            req(0);
        end
        check("idle_wrap", 32'(frame_idx), 0);

        // Bar overlay and back-to-back requests.
        stats = {8'd84, 8'd22, 8'd34};
        req(67);
        req(147);
        req(227);
        req(225);
        idle(2);
        stats = {8'd84, 8'd22, 8'd200};
        for (int unsigned b = 64; b <= 70; b++) req(b);
        idle(2);

        // Pause holds the pending advance; exactly one advance on release.
        pause = 1'b1;
        wait_tick();
        req(0);
        req(0);
        idle(1);
        pause = 1'b0;
        req(0);
        check("pause_one_adv", 32'(frame_idx), 1);
        idle(2);

        // DANDO_AULA to frame 4, then a state change collides with an advance.
        set_estado(5'd8);
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            req(0);
        end
        check("aula_f4", 32'(frame_idx), 4);
        wait_tick();
        req_change(5'd4, 0);
        idle(2);

        // MORTO saturates at frame 7.
        set_estado(5'd16);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            req(0);
        end
        check("morto_hold", 32'(frame_idx), 7);
        req(300);
        idle(2);

        // Invalid code behaves as IDLE.
        set_estado(5'b00011);
        req(10);
        req(71);
        idle(2);

        // Reset with a pending advance in flight.
        set_estado(5'd1);
        wait_tick();
        req(0);
        wait_tick();
        idle(1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        estado = 5'd0;
        idle(2);
        rst_n = 1'b1;
        check("rst2_frame", 32'(frame_idx), 0);
        check("rst2_valid", 32'(data_valid), 0);
        last_data = 8'h00;
        m_est     = 5'd0;
        m_frame   = 0;
        m_pend    = 1'b0;
        chk_en    = 1'b1;
        req(0);
        req(9);
        idle(3);

        check("sb_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
